// File: rtl/serial_frame_receiver_pkg.sv
// Shared constants for the serial link receive path.
// State encodings and line-level framing bits; the framing constants are
// also meant for the matching transmitter.
package serial_frame_receiver_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DATA  = 2'd1;
  localparam logic [1:0] ST_STOP  = 2'd2;
  localparam logic [1:0] ST_BREAK = 2'd3;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/serial_frame_receiver_rx_shift_stage.sv
// rx_shift_stage: WIDTH-bit bidirectional shifter, receive-side mirror of the
// transmit shift register.
// Ports:
//   clk, reset     rising-edge clock, async active-high reset (clears q)
//   en             shift on this edge
//   lsb_first      1: shift right, din enters at MSB; 0: shift left, din enters at LSB
//   din            serial bit in
//   q              shifter contents
module rx_shift_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             lsb_first,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      q <= '0;
    else if (en) begin
      // After WIDTH shifts the first bit received lands in bit 0 (LSB-first)
      // or bit WIDTH-1 (MSB-first).
      if (lsb_first) q <= {din, q[WIDTH-1:1]};
      else           q <= {q[WIDTH-2:0], din};
    end
  end

endmodule

// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver: framed serial receiver (start 0, WIDTH data, stop 1)
// with per-frame selectable bit order and a single-entry valid/ready output.
// Ports:
//   clk, reset   rising-edge clock, async active-high reset
//   bit_en       bit-sample strobe; sin only sampled when high
//   sin          serial line, idles high
//   lsb_first    bit order, captured with the start bit
//   rx_data      received word (held after accept)
//   rx_valid     holding register full
//   rx_ready     consumer accept
//   frame_err    1-cycle pulse: stop bit sampled low
//   overrun      1-cycle pulse: good frame dropped, holding register full
module serial_frame_receiver
  import serial_frame_receiver_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_en,
  input  logic             sin,
  input  logic             lsb_first,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic             lsb_q;
  logic [WIDTH-1:0] sh;

  logic stop_smp, good, accept, load;

  assign stop_smp = bit_en && (state == ST_STOP);
  assign good     = stop_smp && (sin == STOP_BIT);
  assign accept   = rx_valid && rx_ready;
  // A consumer accepting in the same cycle frees the slot for the new word.
  assign load     = good && (!rx_valid || rx_ready);

  rx_shift_stage #(.WIDTH(WIDTH)) u_shift (
    .clk       (clk),
    .reset     (reset),
    .en        (bit_en && (state == ST_DATA)),
    .lsb_first (lsb_q),
    .din       (sin),
    .q         (sh)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      lsb_q <= 1'b0;
    end else if (bit_en) begin
      case (state)
        ST_IDLE: if (sin == START_BIT) begin
          state <= ST_DATA;
          cnt   <= '0;
          lsb_q <= lsb_first;
        end
        ST_DATA: begin
          if (cnt == LAST) begin
            state <= ST_STOP;
            cnt   <= '0;
          end else
            cnt <= cnt + 1'b1;
        end
        ST_STOP:  state <= (sin == STOP_BIT) ? ST_IDLE : ST_BREAK;
        // Held-low line after a framing error must go high before a new start.
        ST_BREAK: if (sin == STOP_BIT) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_smp && (sin != STOP_BIT);
      overrun   <= good && !load;
      if (load) begin
        rx_data  <= sh;
        rx_valid <= 1'b1;
      end else if (accept)
        rx_valid <= 1'b0;
    end
  end

endmodule
